fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
- Owns the fetch-stage PC register and sequences instruction fetch through a variable-latency IM request/acknowledge handshake.
- Applies next-PC redirects with a fixed priority: interrupt/exception entry, then eret return, then D-stage branch/jump/jr target, then PC+4.
- Presents one held instruction to the F/D pipeline register together with its PC and a fetch exception code.
- Sits between the next-PC logic, CP0 (interrupt request and EPC) and instruction memory.

Parameters:
- INIT_PC, 32'h0000_3000, PC value after reset.
- TRAP_PC, 32'h0000_4180, exception handler entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  D stage stalled; F must hold its instruction.
- redirect_i  in  1  D-stage branch taken, jump or jr.
- redirect_pc_i  in  32  target address for redirect_i.
- int_req_i  in  1  CP0 interrupt/exception request; flushes F.
- eret_i  in  1  eret in D; return to EPC.
- epc_i  in  32  EPC value from CP0.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address.
- imem_ack_i  in  1  fetch data valid this cycle.
- imem_rdata_i  in  32  fetched instruction word.
- f_valid_o  out  1  f_instr_o / f_pc_o are valid.
- f_pc_o  out  32  PC of the held instruction.
- f_instr_o  out  32  held instruction word.
- f_exc_o  out  5  fetch exception code: 0 = none, 4 = AdEL.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - pc = INIT_PC, state = IDLE.
  - imem_req_o, f_valid_o, f_instr_o and f_exc_o are 0; f_pc_o = INIT_PC; imem_addr_o = pc.
- States: IDLE, FETCH, READY, DISCARD.
- IDLE:
  - Moves unconditionally to FETCH on the first clock edge after reset is released.
  - If pc is illegal, moves to READY instead (see the legality rule).
- Legality rule, checked on every pc load:
  - pc is illegal when pc[1:0] != 0, pc < IM_LO or pc > IM_HI.
  - An illegal pc never drives imem_req_o.
  - The state goes straight to READY with f_instr_o = 0 (nop), f_exc_o = 4 and f_pc_o = pc.
- FETCH:
  - imem_req_o = 1 and imem_addr_o = pc, both stable until the cycle imem_ack_i = 1.
  - On ack with no redirect: latch imem_rdata_i into f_instr_o, set f_exc_o = 0, go to READY. f_valid_o rises the next cycle, so minimum latency from request to valid is 1 cycle.
- READY:
  - f_valid_o = 1, imem_req_o = 0.
  - If stall_i = 0, the instruction is consumed: pc is loaded with next_pc and the state goes to FETCH.
  - If stall_i = 1, everything holds.
  - Throughput is one instruction per 2 cycles with single-cycle ack.
- next_pc priority:
  - int_req_i gives TRAP_PC.
  - Otherwise eret_i gives epc_i.
  - Otherwise redirect_i with stall_i = 0 gives redirect_pc_i.
  - Otherwise pc + 4, 32-bit modulo arithmetic.
- Flush events:
  - int_req_i and eret_i act regardless of stall_i.
  - redirect_i is ignored while stall_i = 1.
  - In READY, a flush drops the held instruction: f_valid_o goes to 0 the next cycle, pc is loaded with the flush target, and the state goes to FETCH.
  - In FETCH, a flush without ack loads pend_pc with the flush target and the state goes to DISCARD. imem_req_o stays asserted with the old address until ack.
  - In FETCH, a flush with ack in the same cycle drops the data, loads pc with the target and stays in FETCH.
- DISCARD:
  - Waits for imem_ack_i, drops the data, loads pc from pend_pc, goes to FETCH.
  - A new flush during DISCARD overwrites pend_pc, using the same priority.
  - A flush in the same cycle as the ack uses the new target directly.
- Reset asserted mid-operation: immediate return to reset values. An outstanding IM transaction is abandoned, and a late ack in IDLE is ignored.
- Width rules: all addresses are 32-bit unsigned comparisons. f_exc_o is constant 0 or 4.

Decomposition:
- Shared constants package holds:
  - the state encodings;
  - the EXC_ADEL = 5'd4 and EXC_NONE codes;
  - INITIAL_ADDRESS / TRAPPED_ADDRESS, using the existing constants header values for INIT_PC/TRAP_PC.
- One sub-module, fetch_pc_next_sel: combinational priority mux producing next_pc and a flush flag from int_req_i, eret_i, redirect_i, stall_i and pc.
- FSM, PC register and pend_pc stay in the top module.

Test Plan:
- Reset release, ack on the same cycle as every request, stall_i = 0: the request sequence is imem_addr_o 0x3000, 0x3004, 0x3008, and f_valid_o pulses with f_pc_o matching each address.
- Ack delayed 3 cycles at 0x3004: imem_addr_o stays 0x3004 for 4 cycles, and f_instr_o equals imem_rdata_i from the ack cycle.
- redirect_i = 1 with redirect_pc_i = 0x3100 while FETCH waits for ack: the state goes to DISCARD, the data at 0x3004 is dropped, the next request is to 0x3100, and f_valid_o is never asserted for 0x3004.
- int_req_i and eret_i together during READY with stall_i = 1: the held instruction is flushed and the next request is to 0x4180. Repeating with eret_i alone and epc_i = 0x3200 gives a next request to 0x3200.
- redirect_pc_i = 0x3002 (misaligned), then separately 0x7000 (out of range): no imem_req_o is issued, and the next cycle shows f_valid_o = 1, f_instr_o = 0, f_exc_o = 4 and f_pc_o equal to the bad address.
- rst_n driven low mid-FETCH, then an ack arrives while still in reset/IDLE: outputs return to reset values at once, the ack is ignored, and the first request after release is to 0x3000.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer: FSM encoding, fetch exception
// codes, reset/trap addresses and the fetch-address legality check.
package fetch_pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_READY   = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_e;

   localparam logic [4:0]  EXC_NONE        = 5'd0;
   localparam logic [4:0]  EXC_ADEL        = 5'd4;
   localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
   localparam logic [31:0] TRAPPED_ADDRESS = 32'h0000_4180;

   // Word aligned and inside the instruction memory window (unsigned compare).
   function automatic logic pc_legal(input logic [31:0] pc,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
   endfunction

endpackage

// File: rtl/fetch_pc_next_sel.sv
// Next-PC priority mux: trap entry, eret return, D-stage redirect, then PC+4.
// o_flush marks any of the first three, which discard the in-flight fetch.
module fetch_pc_next_sel
   import fetch_pc_sequencer_pkg::*;
#(
   parameter logic [31:0] TRAP_PC = TRAPPED_ADDRESS
) (
   input  logic        i_int_req,
   input  logic        i_eret,
   input  logic [31:0] i_epc,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   input  logic [31:0] i_pc,
   output logic [31:0] o_next_pc,
   output logic        o_flush
);

   always_comb begin
      o_next_pc = i_pc + 32'd4;
      o_flush   = 1'b1;
      if (i_int_req)
         o_next_pc = TRAP_PC;
      else if (i_eret)
         o_next_pc = i_epc;
      else if (i_redirect && !i_stall)
         o_next_pc = i_redirect_pc;
      else
         o_flush = 1'b0;
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC register and IM request/ack sequencer. Holds one fetched
// instruction for the F/D register and applies redirects in priority order.
module fetch_pc_sequencer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter logic [31:0] INIT_PC = INITIAL_ADDRESS,
   parameter logic [31:0] TRAP_PC = TRAPPED_ADDRESS,
   parameter logic [31:0] IM_LO   = 32'h0000_3000,
   parameter logic [31:0] IM_HI   = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        int_req_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        f_valid_o,
   output logic [31:0] f_pc_o,
   output logic [31:0] f_instr_o,
   output logic [4:0]  f_exc_o
);

   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_pc, r_pend_pc, r_instr;
   logic [4:0]   r_exc;
   logic [31:0]  w_next_pc, w_load_val;
   logic         w_flush, w_load, w_pend_load, w_take_data, w_legal;

   fetch_pc_next_sel #(.TRAP_PC(TRAP_PC)) u_next_sel (
      .i_int_req     (int_req_i),
      .i_eret        (eret_i),
      .i_epc         (epc_i),
      .i_redirect    (redirect_i),
      .i_redirect_pc (redirect_pc_i),
      .i_stall       (stall_i),
      .i_pc          (r_pc),
      .o_next_pc     (w_next_pc),
      .o_flush       (w_flush)
   );

   assign w_legal = pc_legal(w_load_val, IM_LO, IM_HI);

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = w_next_pc;
      w_pend_load = 1'b0;
      w_take_data = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Re-load the reset PC so it passes through the legality check.
            w_load     = 1'b1;
            w_load_val = r_pc;
         end
         ST_FETCH: begin
            if (imem_ack_i) begin
               if (w_flush) begin
                  w_load = 1'b1;
               end else begin
                  w_take_data = 1'b1;
                  w_state_nxt = ST_READY;
               end
            end else if (w_flush) begin
               w_pend_load = 1'b1;
               w_state_nxt = ST_DISCARD;
            end
         end
         ST_READY: begin
            if (w_flush || !stall_i)
               w_load = 1'b1;
         end
         ST_DISCARD: begin
            // The old request must complete before the pending target is fetched.
            if (imem_ack_i) begin
               w_load = 1'b1;
               if (!w_flush)
                  w_load_val = r_pend_pc;
            end else if (w_flush) begin
               w_pend_load = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_load)
         w_state_nxt = w_legal ? ST_FETCH : ST_READY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pc      <= INIT_PC;
         r_pend_pc <= INIT_PC;
         r_instr   <= '0;
         r_exc     <= EXC_NONE;
      end else begin
         r_state <= w_state_nxt;
         if (w_load)
            r_pc <= w_load_val;
         if (w_pend_load)
            r_pend_pc <= w_next_pc;
         if (w_take_data) begin
            r_instr <= imem_rdata_i;
            r_exc   <= EXC_NONE;
         end else if (w_load && !w_legal) begin
            r_instr <= '0;
            r_exc   <= EXC_ADEL;
         end
      end
   end

   assign imem_req_o  = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
   assign imem_addr_o = r_pc;
   assign f_valid_o   = (r_state == ST_READY);
   assign f_pc_o      = r_pc;
   assign f_instr_o   = r_instr;
   assign f_exc_o     = r_exc;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with a scoreboard of expected fetch
// addresses and expected F-stage outputs.
module tb_fetch_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, redirect_i, int_req_i, eret_i, imem_ack_i;
   logic [31:0] redirect_pc_i, epc_i, imem_rdata_i;
   logic        imem_req_o, f_valid_o;
   logic [31:0] imem_addr_o, f_pc_o, f_instr_o;
   logic [4:0]  f_exc_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] q_addr[$];
   logic [68:0] q_out[$];

   fetch_pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .int_req_i     (int_req_i),
      .eret_i        (eret_i),
      .epc_i         (epc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .f_valid_o     (f_valid_o),
      .f_pc_o        (f_pc_o),
      .f_instr_o     (f_instr_o),
      .f_exc_o       (f_exc_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc);
      q_out.push_back({pc, instr, exc});
   endtask

   // Wait (bounded) for a request, then compare its address with the scoreboard.
   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && !imem_req_o; i++) tick();
      chk({tag, "_req"}, 69'(imem_req_o), 69'(1));
      chk({tag, "_addr"}, 69'(imem_addr_o), 69'(q_addr.pop_front()));
   endtask

   // Ack after n wait cycles, checking the address stays stable meanwhile.
   task automatic ack_after(input string tag, input int n, input logic [31:0] data);
      logic [31:0] a;
      a = imem_addr_o;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_hold"}, {37'(imem_req_o), imem_addr_o}, {37'(1), a});
         tick();
      end
      chk({tag, "_hold"}, {37'(imem_req_o), imem_addr_o}, {37'(1), a});
      imem_ack_i   = 1'b1;
      imem_rdata_i = data;
      tick();
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_valid"}, 69'(f_valid_o), 69'(1));
      chk({tag, "_out"}, {f_pc_o, f_instr_o, f_exc_o}, q_out.pop_front());
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stall_i = 0; redirect_i = 0; int_req_i = 0; eret_i = 0; imem_ack_i = 0;
      redirect_pc_i = 0; epc_i = 0; imem_rdata_i = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state", {1'b0, imem_req_o, f_valid_o, f_instr_o, f_exc_o, f_pc_o[29:0]},
          {1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 30'h3000});
      chk("rst_addr", 69'(imem_addr_o), 69'(32'h3000));
      tick();
      rst_n = 1'b1;

      // Back-to-back fetches with single-cycle ack
      for (int i = 0; i < 3; i++) begin
         q_addr.push_back(32'h3000 + 32'(i * 4));
         push_out(32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 5'd0);
      end
      for (int i = 0; i < 3; i++) begin
         wait_req("seq");
         ack_after("seq", 0, 32'hA000_0000 + 32'(i));
         check_out("seq");
      end

      // Ack delayed 3 cycles at 0x3004
      do_reset();
      q_addr.push_back(32'h3000); q_addr.push_back(32'h3004);
      push_out(32'h3000, 32'h1111_1111, 5'd0);
      push_out(32'h3004, 32'h2222_2222, 5'd0);
      wait_req("dly0");
      ack_after("dly0", 0, 32'h1111_1111);
      check_out("dly0");
      tick();
      wait_req("dly1");
      ack_after("dly1", 3, 32'h2222_2222);
      check_out("dly1");

      // Redirect while waiting for ack goes through DISCARD
      do_reset();
      q_addr.push_back(32'h3000); q_addr.push_back(32'h3004); q_addr.push_back(32'h3100);
      push_out(32'h3000, 32'h3333_0000, 5'd0);
      push_out(32'h3100, 32'h3333_3100, 5'd0);
      wait_req("rd0");
      ack_after("rd0", 0, 32'h3333_0000);
      check_out("rd0");
      tick();
      wait_req("rd1");
      redirect_i = 1'b1; redirect_pc_i = 32'h3100;
      tick();
      redirect_i = 1'b0;
      chk("discard_hold", {36'(imem_req_o), f_valid_o, imem_addr_o}, {36'(1), 1'b0, 32'h3004});
      tick();
      chk("discard_novalid", 69'(f_valid_o), 69'(0));
      imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_3004;
      tick();
      imem_ack_i = 1'b0;
      chk("discard_drop", 69'(f_valid_o), 69'(0));
      wait_req("rd2");
      ack_after("rd2", 0, 32'h3333_3100);
      check_out("rd2");

      // Interrupt + eret during stalled READY; then eret alone
      do_reset();
      q_addr.push_back(32'h3000); q_addr.push_back(32'h4180); q_addr.push_back(32'h3200);
      push_out(32'h3000, 32'h4444_0000, 5'd0);
      push_out(32'h3000, 32'h4444_0000, 5'd0);
      push_out(32'h4180, 32'h4444_4180, 5'd0);
      wait_req("int0");
      ack_after("int0", 0, 32'h4444_0000);
      stall_i = 1'b1;
      check_out("int0");
      tick();
      check_out("stall_hold");
      int_req_i = 1'b1; eret_i = 1'b1; epc_i = 32'h3200;
      tick();
      int_req_i = 1'b0; eret_i = 1'b0;
      chk("int_flush", 69'(f_valid_o), 69'(0));
      wait_req("int1");
      ack_after("int1", 0, 32'h4444_4180);
      check_out("int1");
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      chk("eret_flush", 69'(f_valid_o), 69'(0));
      wait_req("eret");
      stall_i = 1'b0;

      // Misaligned and out-of-range redirect targets raise AdEL without a request
      do_reset();
      q_addr.push_back(32'h3000); q_addr.push_back(32'h3000);
      push_out(32'h3000, 32'h5555_0000, 5'd0);
      push_out(32'h3002, 32'h0, 5'd4);
      push_out(32'h7000, 32'h0, 5'd4);
      push_out(32'h3000, 32'h5555_3000, 5'd0);
      wait_req("adel0");
      ack_after("adel0", 0, 32'h5555_0000);
      check_out("adel0");
      redirect_i = 1'b1; redirect_pc_i = 32'h3002;
      tick();
      chk("adel_noreq_mis", 69'(imem_req_o), 69'(0));
      check_out("adel_mis");
      redirect_pc_i = 32'h7000;
      tick();
      chk("adel_noreq_rng", 69'(imem_req_o), 69'(0));
      check_out("adel_rng");
      redirect_pc_i = 32'h3000;
      tick();
      redirect_i = 1'b0;
      wait_req("adel1");
      ack_after("adel1", 0, 32'h5555_3000);
      check_out("adel1");

      // Reset mid-FETCH, late ack during reset and IDLE is ignored
      do_reset();
      q_addr.push_back(32'h3000); q_addr.push_back(32'h3004); q_addr.push_back(32'h3000);
      push_out(32'h3000, 32'h6666_0000, 5'd0);
      push_out(32'h3000, 32'h6666_3000, 5'd0);
      wait_req("mr0");
      ack_after("mr0", 0, 32'h6666_0000);
      check_out("mr0");
      tick();
      wait_req("mr1");
      rst_n = 1'b0;
      #1;
      chk("mr_rst", {1'b0, imem_req_o, f_valid_o, f_instr_o, f_exc_o, f_pc_o[29:0]},
          {1'b0, 1'b0, 1'b0, 32'h0, 5'h0, 30'h3000});
      chk("mr_rst_addr", 69'(imem_addr_o), 69'(32'h3000));
      imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_0001;
      tick();
      rst_n = 1'b1;
      tick();
      imem_ack_i = 1'b0;
      chk("mr_late_ack", {37'(f_valid_o), f_instr_o}, {37'(0), 32'h0});
      wait_req("mr2");
      ack_after("mr2", 0, 32'h6666_3000);
      check_out("mr2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
